decode_r32i: RTL

Instruction decode stage for the RISCV32I core, directly upstream of the register file. Holds one fetched instruction in an ID buffer, drives register file read addresses from it, decodes fields and immediate for execute, and (optionally) stalls on read-after-write hazards using a pending-write scoreboard cleared by writeback.

---
 rtl/r32i_pkg.sv | 44 ++++
 rtl/decode_r32i_if.sv | 39 +++
 rtl/imm_gen_r32i.sv | 42 ++++
 rtl/decode_r32i.sv | 106 ++++++++++
 4 files changed

// File: rtl/r32i_pkg.sv
// Shared RV32I decode definitions: base opcodes, instruction formats and ID buffer states.
package r32i_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP       = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] LOAD     = 7'h03;
  localparam logic [6:0] STORE    = 7'h23;
  localparam logic [6:0] BRANCH   = 7'h63;
  localparam logic [6:0] JAL      = 7'h6F;
  localparam logic [6:0] JALR     = 7'h67;
  localparam logic [6:0] LUI      = 7'h37;
  localparam logic [6:0] AUIPC    = 7'h17;
  localparam logic [6:0] SYSTEM   = 7'h73;
  localparam logic [6:0] MISC_MEM = 7'h0F;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  function automatic logic fmt_uses_rs1(fmt_t f);
    return f inside {FMT_R, FMT_I, FMT_S, FMT_B};
  endfunction

  function automatic logic fmt_uses_rs2(fmt_t f);
    return f inside {FMT_R, FMT_S, FMT_B};
  endfunction

  function automatic logic fmt_writes_rd(fmt_t f);
    return f inside {FMT_R, FMT_I, FMT_U, FMT_J};
  endfunction

endpackage

// File: rtl/decode_r32i_if.sv
// Decode stage bus: fetch handshake, register-file read addresses, execute handshake, writeback.
interface decode_r32i_if
  import r32i_pkg::*;
#(parameter int dataW = 32);

  logic                  InstrValid;
  logic                  InstrReady;
  logic [31:0]           InstrData;
  logic [dataW-1:0]      InstrPc;
  logic                  Flush;
  logic [dataW-1:0]      RegData1;
  logic [dataW-1:0]      RegData2;
  logic                  ExValid;
  logic                  ExReady;
  logic [dataW-1:0]      ExPc;
  logic [REG_ADDR_W-1:0] ExRd;
  logic [dataW-1:0]      ExImm;
  logic [2:0]            ExFormat;
  logic [6:0]            ExOpcode;
  logic [2:0]            ExFunct3;
  logic                  ExFunct7b5;
  logic                  ExRegWrite;
  logic                  ExIllegal;
  logic                  WbValid;
  logic [REG_ADDR_W-1:0] WbAddr;

  modport slave (
    input  InstrValid, InstrData, InstrPc, Flush, ExReady, WbValid, WbAddr,
    output InstrReady, RegData1, RegData2, ExValid, ExPc, ExRd, ExImm, ExFormat,
           ExOpcode, ExFunct3, ExFunct7b5, ExRegWrite, ExIllegal
  );

  modport master (
    output InstrValid, InstrData, InstrPc, Flush, ExReady, WbValid, WbAddr,
    input  InstrReady, RegData1, RegData2, ExValid, ExPc, ExRd, ExImm, ExFormat,
           ExOpcode, ExFunct3, ExFunct7b5, ExRegWrite, ExIllegal
  );

endinterface

// File: rtl/imm_gen_r32i.sv
// Combinational RV32I format classification, immediate extraction and illegal-opcode detect.
module imm_gen_r32i
  import r32i_pkg::*;
#(parameter int dataW = 32) (
  input  logic [31:0]      instr,
  output fmt_t             format,
  output logic [dataW-1:0] imm,
  output logic             illegal
);

  logic [31:0] imm32;

  always_comb begin
    format  = FMT_R;
    illegal = 1'b0;
    case (instr[6:0])
      OP:                                   format = FMT_R;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: format = FMT_I;
      STORE:                                format = FMT_S;
      BRANCH:                               format = FMT_B;
      LUI, AUIPC:                           format = FMT_U;
      JAL:                                  format = FMT_J;
      default:                              illegal = 1'b1;
    endcase
  end

  // Illegal opcodes fall through as FMT_R, so their immediate reads as zero.
  always_comb begin
    imm32 = '0;
    case (format)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = dataW'(signed'(imm32));

endmodule

// File: rtl/decode_r32i.sv
// RV32I ID stage: one-entry instruction buffer, register-file address drive and field decode.
// Defining DECODE_SCOREBOARD_EN adds a pending-write scoreboard that stalls on RAW hazards.
module decode_r32i
  import r32i_pkg::*;
#(parameter int dataW = 32) (
  input  logic          clock,
  input  logic          reset,
  decode_r32i_if.slave  bus
);

  // state     | meaning
  // BUF_EMPTY | no instruction held, fetch may load the buffer
  // BUF_FULL  | instruction held and offered to execute

  buf_state_t            state, state_nxt;
  logic [31:0]           instr_q;
  logic [dataW-1:0]      pc_q;
  logic                  full, accept, issue, hazard;
  fmt_t                  fmt;
  logic [dataW-1:0]      imm;
  logic                  illegal;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic                  use_rs1, use_rs2, reg_write;

  always_ff @(posedge clock) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.Flush)  state_nxt = BUF_EMPTY;
    else if (accept) state_nxt = BUF_FULL;
    else if (issue)  state_nxt = BUF_EMPTY;
  end

  assign full = (state == BUF_FULL);

  always_comb begin
    bus.ExValid    = full && !hazard;
    issue          = full && !hazard && bus.ExReady;
    bus.InstrReady = !full || issue;
    accept         = bus.InstrValid && (!full || issue);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (accept && !bus.Flush) begin
      instr_q <= bus.InstrData;
      pc_q    <= bus.InstrPc;
    end
  end

  imm_gen_r32i #(.dataW(dataW)) u_imm_gen (
    .instr   (instr_q),
    .format  (fmt),
    .imm     (imm),
    .illegal (illegal)
  );

  assign rd  = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  assign use_rs1   = full && !illegal && fmt_uses_rs1(fmt);
  assign use_rs2   = full && !illegal && fmt_uses_rs2(fmt);
  assign reg_write = full && !illegal && (rd != '0) && fmt_writes_rd(fmt);

  assign bus.RegData1   = use_rs1 ? dataW'(rs1) : '0;
  assign bus.RegData2   = use_rs2 ? dataW'(rs2) : '0;
  assign bus.ExPc       = full ? pc_q : '0;
  assign bus.ExRd       = full ? rd : '0;
  assign bus.ExImm      = full ? imm : '0;
  assign bus.ExFormat   = full ? 3'(fmt) : 3'd0;
  assign bus.ExOpcode   = full ? instr_q[6:0] : 7'd0;
  assign bus.ExFunct3   = full ? instr_q[14:12] : 3'd0;
  assign bus.ExFunct7b5 = full && instr_q[30];
  assign bus.ExRegWrite = reg_write;
  assign bus.ExIllegal  = full && illegal;

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] pending, pending_nxt;

  // A register issued and retired in the same cycle stays pending: the set is newer.
  always_comb begin
    pending_nxt = pending;
    if (bus.WbValid)        pending_nxt[bus.WbAddr] = 1'b0;
    if (issue && reg_write) pending_nxt[rd]         = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign hazard = (use_rs1 && pending[rs1]) || (use_rs2 && pending[rs2]);
`else
  logic unused_wb;
  assign unused_wb = ^{bus.WbValid, bus.WbAddr};
  assign hazard    = 1'b0;
`endif

endmodule
